// File: rtl/tick_scheduler_pkg.sv
// Shared types and default constants for the tick scheduler.
package tick_scheduler_pkg;

  localparam int unsigned DEF_N_CH     = 4;
  localparam int unsigned DEF_BASE_DIV = 240;
  localparam int unsigned DEF_PER_W    = 16;

  typedef enum logic {
    CFG_IDLE  = 1'b0,
    CFG_APPLY = 1'b1
  } cfg_state_e;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Base-tick prescaler: one-cycle strobe every BASE_DIV clock cycles.
module tick_prescaler
  import tick_scheduler_pkg::*;
#(
  parameter int unsigned BASE_DIV = DEF_BASE_DIV
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam int unsigned CNT_W = idx_w(BASE_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             wrap;

  assign wrap = (cnt_q == CNT_W'(BASE_DIV - 1));

  always_comb begin
    cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
    tick_d = wrap;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign o_tick = tick_q;

endmodule

// File: rtl/tick_scheduler.sv
// Periodic event scheduler: per-channel base-tick dividers, pending/overrun
// tracking, round-robin arbitration into a registered output slot.
module tick_scheduler
  import tick_scheduler_pkg::*;
#(
  parameter  int unsigned N_CH     = DEF_N_CH,
  parameter  int unsigned BASE_DIV = DEF_BASE_DIV,
  parameter  int unsigned PER_W    = DEF_PER_W,
  localparam int unsigned CH_W     = idx_w(N_CH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [CH_W-1:0]  i_cfg_ch,
  input  logic [PER_W-1:0] i_cfg_period,
  output logic             o_base_tick,
  output logic             o_evt_valid,
  output logic [CH_W-1:0]  o_evt_ch,
  input  logic             i_evt_ready,
  output logic [N_CH-1:0]  o_overrun
);

  logic base_tick;

  tick_prescaler #(
    .BASE_DIV (BASE_DIV)
  ) u_prescaler (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_tick  (base_tick)
  );

  assign o_base_tick = base_tick;

  // Config FSM: accept one request, apply it on the following cycle.
  cfg_state_e       state_q, state_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic [CH_W-1:0]  cap_ch_q, cap_ch_d;
  logic [PER_W-1:0] cap_per_q, cap_per_d;
  logic             cfg_accept;

  assign cfg_accept = i_cfg_valid & cfg_ready_q;

  always_comb begin
    state_d   = state_q;
    cap_ch_d  = cap_ch_q;
    cap_per_d = cap_per_q;
    case (state_q)
      CFG_IDLE: begin
        if (cfg_accept) begin
          state_d   = CFG_APPLY;
          cap_ch_d  = i_cfg_ch;
          cap_per_d = i_cfg_period;
        end
      end
      CFG_APPLY: state_d = CFG_IDLE;
      default:   state_d = CFG_IDLE;
    endcase
    cfg_ready_d = (state_d == CFG_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= CFG_IDLE;
      cfg_ready_q <= 1'b0;
      cap_ch_q    <= '0;
      cap_per_q   <= '0;
    end else begin
      state_q     <= state_d;
      cfg_ready_q <= cfg_ready_d;
      cap_ch_q    <= cap_ch_d;
      cap_per_q   <= cap_per_d;
    end
  end

  assign o_cfg_ready = cfg_ready_q;

  // Channel array state.
  logic [PER_W-1:0] per_q [N_CH];
  logic [PER_W-1:0] per_d [N_CH];
  logic [PER_W-1:0] cnt_q [N_CH];
  logic [PER_W-1:0] cnt_d [N_CH];
  logic [N_CH-1:0]  pend_q, pend_d;
  logic [N_CH-1:0]  ovr_q, ovr_d;
  logic [N_CH-1:0]  fire, apply, req, grant;

  always_comb begin
    fire  = '0;
    apply = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      apply[i] = (state_q == CFG_APPLY) && (cap_ch_q == CH_W'(i));
      fire[i]  = base_tick && (per_q[i] != '0) &&
                 (cnt_q[i] == per_q[i] - PER_W'(1));
    end
  end

  // A channel being reconfigured drops its pending event instead of granting it.
  assign req = pend_q & ~apply;

  // Output slot and round-robin arbiter.
  logic            evt_valid_q, evt_valid_d;
  logic [CH_W-1:0] evt_ch_q, evt_ch_d;
  logic [CH_W-1:0] rr_q, rr_d;
  logic            slot_load;
  logic            found;
  logic [CH_W-1:0] win;
  logic [CH_W-1:0] srch;

  assign slot_load = !evt_valid_q || i_evt_ready;

  always_comb begin
    found = 1'b0;
    win   = '0;
    srch  = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      srch = CH_W'((32'(rr_q) + 32'd1 + k) % N_CH);
      if (!found && req[srch]) begin
        found = 1'b1;
        win   = srch;
      end
    end
    grant = '0;
    if (slot_load && found) grant[win] = 1'b1;
  end

  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    rr_d        = rr_q;
    if (slot_load) begin
      evt_valid_d = found;
      if (found) begin
        evt_ch_d = win;
        rr_d     = win;
      end
    end
  end

  // Per-channel next state; apply dominates fire, fire dominates grant-clear.
  always_comb begin
    pend_d = pend_q;
    ovr_d  = ovr_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      per_d[i] = per_q[i];
      cnt_d[i] = cnt_q[i];
      if (apply[i]) begin
        per_d[i]  = cap_per_q;
        cnt_d[i]  = '0;
        pend_d[i] = 1'b0;
        ovr_d[i]  = 1'b0;
      end else begin
        if (base_tick && (per_q[i] != '0)) begin
          cnt_d[i] = fire[i] ? '0 : cnt_q[i] + PER_W'(1);
        end
        if (fire[i]) begin
          pend_d[i] = 1'b1;
          if (pend_q[i] && !grant[i]) ovr_d[i] = 1'b1;
        end else if (grant[i]) begin
          pend_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        per_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      pend_q      <= '0;
      ovr_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      rr_q        <= CH_W'(N_CH - 1);
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        per_q[i] <= per_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      pend_q      <= pend_d;
      ovr_q       <= ovr_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      rr_q        <= rr_d;
    end
  end

  assign o_evt_valid = evt_valid_q;
  assign o_evt_ch    = evt_ch_q;
  assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: directed phases plus random traffic against a
// tick-counting reference model.
module tb_tick_scheduler;

  localparam int unsigned NC  = 4;
  localparam int unsigned BD  = 4;
  localparam int unsigned PW  = 8;
  localparam int unsigned CW  = 2;

  logic          clk;
  logic          reset;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_ch;
  logic [PW-1:0] cfg_period;
  logic          base_tick;
  logic          evt_valid;
  logic [CW-1:0] evt_ch;
  logic          evt_ready;
  logic [NC-1:0] overrun;

  tick_scheduler #(
    .N_CH     (NC),
    .BASE_DIV (BD),
    .PER_W    (PW)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_cfg_valid  (cfg_valid),
    .o_cfg_ready  (cfg_ready),
    .i_cfg_ch     (cfg_ch),
    .i_cfg_period (cfg_period),
    .o_base_tick  (base_tick),
    .o_evt_valid  (evt_valid),
    .o_evt_ch     (evt_ch),
    .i_evt_ready  (evt_ready),
    .o_overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: cycles since reset, base ticks seen per channel since
  // its last configuration, a pending set and a one-entry output slot.
  int m_cyc;
  bit m_ready;
  bit m_busy;
  int m_cap_ch;
  int m_cap_per;
  int m_per  [NC];
  int m_n    [NC];
  bit m_pend [NC];
  bit m_ovr  [NC];
  bit m_slot_v;
  int m_slot_ch;
  int m_rr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc     = 0;
    m_ready   = 1'b0;
    m_busy    = 1'b0;
    m_cap_ch  = 0;
    m_cap_per = 0;
    for (int i = 0; i < NC; i++) begin
      m_per[i]  = 0;
      m_n[i]    = 0;
      m_pend[i] = 1'b0;
      m_ovr[i]  = 1'b0;
    end
    m_slot_v  = 1'b0;
    m_slot_ch = 0;
    m_rr      = NC - 1;
  endtask

  // Advance model and DUT by one clock with the currently driven inputs.
  task automatic step();
    bit tick;
    bit fire [NC];
    int apply_ch;
    int gr;
    int idx;
    bit accept;
    bit load;
    logic [31:0] exp_ovr;
    if (reset) begin
      model_reset();
    end else begin
      tick     = (m_cyc > 0) && (m_cyc % BD == 0);
      apply_ch = m_busy ? m_cap_ch : -1;
      for (int i = 0; i < NC; i++)
        fire[i] = tick && (m_per[i] > 0) && ((m_n[i] + 1) % m_per[i] == 0) && (i != apply_ch);
      load = !m_slot_v || evt_ready;
      gr   = -1;
      if (load) begin
        for (int k = 0; k < NC; k++) begin
          idx = (m_rr + 1 + k) % NC;
          if (gr < 0 && m_pend[idx] && idx != apply_ch) gr = idx;
        end
      end
      for (int i = 0; i < NC; i++) begin
        if (i == apply_ch) begin
          m_per[i]  = m_cap_per;
          m_n[i]    = 0;
          m_pend[i] = 1'b0;
          m_ovr[i]  = 1'b0;
        end else begin
          if (tick) m_n[i]++;
          if (fire[i]) begin
            if (m_pend[i] && gr != i) m_ovr[i] = 1'b1;
            m_pend[i] = 1'b1;
          end else if (gr == i) begin
            m_pend[i] = 1'b0;
          end
        end
      end
      if (load) begin
        m_slot_v = (gr >= 0);
        if (gr >= 0) begin
          m_slot_ch = gr;
          m_rr      = gr;
        end
      end
      accept = cfg_valid && m_ready;
      if (m_busy) begin
        m_busy = 1'b0;
      end else if (accept) begin
        m_busy    = 1'b1;
        m_cap_ch  = int'(cfg_ch);
        m_cap_per = int'(cfg_period);
      end
      m_ready = !accept;
      m_cyc++;
    end
    @(posedge clk);
    #1;
    exp_ovr = '0;
    for (int i = 0; i < NC; i++) exp_ovr[i] = m_ovr[i];
    check("base_tick", 32'(base_tick), 32'((m_cyc > 0) && (m_cyc % BD == 0)));
    check("cfg_ready", 32'(cfg_ready), 32'(m_ready));
    check("evt_valid", 32'(evt_valid), 32'(m_slot_v));
    check("overrun",   32'(overrun),   exp_ovr);
    if (m_slot_v || reset) check("evt_ch", 32'(evt_ch), 32'(m_slot_ch));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Hold a request until the model says it was accepted (bounded).
  task automatic do_cfg(input int ch, input int per);
    bit acc;
    cfg_valid  = 1'b1;
    cfg_ch     = CW'(ch);
    cfg_period = PW'(per);
    for (int t = 0; t < 8; t++) begin
      acc = m_ready;
      step();
      if (acc) break;
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    cfg_valid  = 1'b0;
    cfg_ch     = '0;
    cfg_period = '0;
    evt_ready  = 1'b1;
    model_reset();
    run(3);
    reset = 1'b0;

    // Single channel, period 3.
    do_cfg(0, 3);
    run(40);

    // All channels period 1, back-to-back config.
    do_cfg(1, 1);
    do_cfg(2, 1);
    do_cfg(3, 1);
    do_cfg(0, 1);
    run(40);

    // Stalled consumer on ch2, then reconfigure to clear overrun.
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    evt_ready = 1'b0;
    do_cfg(2, 1);
    run(16);
    do_cfg(2, 2);
    run(10);
    evt_ready = 1'b1;
    run(10);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      cfg_valid  = ($urandom_range(7, 0) == 0);
      cfg_ch     = CW'($urandom_range(NC - 1, 0));
      cfg_period = PW'($urandom_range(5, 0));
      evt_ready  = ($urandom_range(3, 0) != 0);
      step();
    end
    cfg_valid = 1'b0;

    // Reset pulse while an event is presented, then silence.
    do_cfg(1, 1);
    evt_ready = 1'b0;
    run(12);
    reset = 1'b1;
    step();
    reset = 1'b0;
    evt_ready = 1'b1;
    run(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
